ddr4_cmd_encoder: RTL and testbench
===================================

# ddr4_cmd_encoder

Drives a DDR4 command/address bus (CS_n, ACT_n, adr, ba, bg) from a valid/ready request stream of high-level operations. It tracks which of the 16 bank/bank-group slots have an open row, enforces minimum command spacing, and rejects illegal sequences. It is the transmit side of the command-decode monitor in the NoC/DDRMC performance-simulation bench, and generates traffic that the monitor decodes back into identical per-command counts.

## Interface
Parameters:
- T_RCD, 4: minimum bus-cycle spacing from ACT to RD/WR (≥1).
- T_RP, 4: minimum spacing from PRE/PREA to the next ACT or REF (≥1).
- T_RFC, 16: minimum spacing from REF to any command (≥1).
- T_CCD, 2: minimum spacing between consecutive RD/WR (≥1).

Ports:
- clk  in  1  command clock; all logic on posedge.
- rst  in  1  reset, asynchronous, active-high.
- req_valid  in  1  request present.
- req_ready  out  1  request accepted when req_valid && req_ready at posedge.
- req_op  in  3  0=ACT, 1=RD, 2=WR, 3=PRE, 4=PREA, 5=REF, 6=MRS, 7=NOP.
- req_ba  in  2  bank address.
- req_bg  in  2  bank group.
- req_row  in  17  row for ACT; MRS payload in [13:0].
- req_col  in  10  column for RD/WR.
- CS_n  out  1  chip select, active low.
- ACT_n  out  1  activate, active low.
- adr  out  17  address/command bits.
- ba  out  2  bank address.
- bg  out  2  bank group.
- issued  out  1  one-cycle pulse on the cycle a command is on the bus.
- err  out  1  one-cycle pulse when a request is dropped as illegal.
- cmd_count  out  17  number of commands issued, wrapping.

## Operation
- Bus encoding (CS_n=0 unless stated): ACT: ACT_n=0, adr=row. For all others ACT_n=1 and adr[16:14] is the opcode. MRS=000, adr[13:0]=req_row[13:0]. REF=001. PRE=010 with adr[10]=0. PREA=010 with adr[10]=1. WR=100. RD=101. NOP=111. For RD/WR, adr[9:0]=col and adr[13:10]=0. All unused adr bits are 0. ba/bg always carry the request fields.
- Idle/deselect: CS_n=1, ACT_n=1, adr=17'h1FFFF, ba=0, bg=0.
- One-entry hold register. States: EMPTY, HELD.
  - EMPTY→HELD on accept.
  - In HELD, the command issues when its timer is 0.
  - On issue, the register returns to EMPTY, or reloads if a new request is accepted on the same edge.
- req_ready = EMPTY || (HELD && issuing this cycle). This gives 1 command/cycle throughput.
- Bank state: open_mask[15:0], indexed {ba,bg}.
  - ACT sets the bit. PRE clears it. PREA clears all bits.
- Legality is checked when the command would issue. An illegal command is dropped: no bus activity, err pulses, and the hold empties. Illegal cases:
  - ACT to an open slot.
  - RD/WR to a closed slot.
  - REF or MRS while open_mask≠0.
- PRE to a closed slot is legal (no-op on the mask).
- NOP issues its encoding and is not subject to timers.

## Timing
- Accept at edge k. Earliest issue: bus driven from edge k+1 for exactly one cycle, then returns to deselect unless the next command issues.
- Timers load X−1 on the issue edge and decrement to 0. Eligibility requires 0. Bus edges of constrained pairs are therefore ≥X apart.
  - rcd_cnt: loaded by ACT; gates RD/WR (global, not per bank).
  - rp_cnt: loaded by PRE/PREA; gates ACT and REF.
  - rfc_cnt: loaded by REF; gates everything except NOP.
  - ccd_cnt: loaded by RD/WR; gates RD/WR.
- Blocked commands wait in HELD with bus deselected. Legality is re-evaluated at actual issue.
- issued is coincident with bus drive. cmd_count increments on the same edge, wraps 17'h1FFFF→0, and excludes dropped requests.
- Reset (any time, including HELD or a timer mid-count): bus to deselect, hold EMPTY, open_mask=0, all timers=0, issued=0, err=0, cmd_count=0, req_ready=1 from the first edge after release.

## Structure
- Shared package (shared with the decode monitor): op enum, opcode constants (3'b000…3'b111), PREA bit index 10, deselect address value.
- Sub-module ddr4_timer: loadable down-counter with a zero flag, instantiated 4×.

## Test plan
- ACT(bg0,ba0,row 0x1234) then RD(col 0x10), back-to-back valid:
  - ACT on bus at edge 1 with adr=0x01234.
  - RD at edge 1+T_RCD=5 with adr=0x14010.
  - req_ready low for edges 2–4.
- Four RDs to an open bank, back-to-back → bus edges spaced by T_CCD=2; cmd_count goes +4.
- RD to a closed slot → err pulse, bus stays deselected, cmd_count unchanged, next request accepted immediately.
- PREA then REF then ACT:
  - PREA with adr=0x08400.
  - REF T_RP=4 cycles later with adr=0x04000.
  - ACT T_RFC=16 cycles after REF.
- REF with slot 5 open → err; after PRE to slot 5, REF issues.
- Reset asserted while HELD with rfc_cnt=10 → bus at deselect (adr=0x1FFFF), open_mask=0, and after release the first request issues with no wait.

Source files
------------

// File: rtl/ddr4_cmd_encoder_pkg.sv
// Shared definitions for the DDR4 command encoder and its decode monitor:
// request op codes, bus opcodes, and the request-to-bus encoding.
package ddr4_cmd_encoder_pkg;

    typedef enum logic [2:0] {
        OP_ACT  = 3'd0,
        OP_RD   = 3'd1,
        OP_WR   = 3'd2,
        OP_PRE  = 3'd3,
        OP_PREA = 3'd4,
        OP_REF  = 3'd5,
        OP_MRS  = 3'd6,
        OP_NOP  = 3'd7
    } op_e;

    // Opcode carried in adr[16:14] when ACT_n is high
    localparam logic [2:0] CMD_MRS = 3'b000;
    localparam logic [2:0] CMD_REF = 3'b001;
    localparam logic [2:0] CMD_PRE = 3'b010;
    localparam logic [2:0] CMD_WR  = 3'b100;
    localparam logic [2:0] CMD_RD  = 3'b101;
    localparam logic [2:0] CMD_NOP = 3'b111;

    localparam int          PREA_BIT     = 10;
    localparam logic [16:0] ADR_DESELECT = 17'h1FFFF;

    typedef struct packed {
        op_e         op;
        logic [1:0]  ba;
        logic [1:0]  bg;
        logic [16:0] row;
        logic [9:0]  col;
    } req_t;

    typedef struct packed {
        logic        cs_n;
        logic        act_n;
        logic [16:0] adr;
        logic [1:0]  ba;
        logic [1:0]  bg;
    } bus_t;

    function automatic bus_t bus_deselect();
        bus_t b;
        b.cs_n  = 1'b1;
        b.act_n = 1'b1;
        b.adr   = ADR_DESELECT;
        b.ba    = 2'd0;
        b.bg    = 2'd0;
        return b;
    endfunction

    function automatic bus_t bus_encode(req_t r);
        bus_t b;
        b.cs_n  = 1'b0;
        b.act_n = 1'b1;
        b.adr   = '0;
        b.ba    = r.ba;
        b.bg    = r.bg;
        case (r.op)
            OP_ACT: begin
                b.act_n = 1'b0;
                b.adr   = r.row;
            end
            OP_RD: begin
                b.adr[16:14] = CMD_RD;
                b.adr[9:0]   = r.col;
            end
            OP_WR: begin
                b.adr[16:14] = CMD_WR;
                b.adr[9:0]   = r.col;
            end
            OP_PRE:  b.adr[16:14] = CMD_PRE;
            OP_PREA: begin
                b.adr[16:14]    = CMD_PRE;
                b.adr[PREA_BIT] = 1'b1;
            end
            OP_REF:  b.adr[16:14] = CMD_REF;
            OP_MRS: begin
                b.adr[16:14] = CMD_MRS;
                b.adr[13:0]  = r.row[13:0];
            end
            default: b.adr[16:14] = CMD_NOP;
        endcase
        return b;
    endfunction

endpackage

// File: rtl/ddr4_timer.sv
// Loadable down-counter: load sets PERIOD-1, then counts down and holds at 0.
module ddr4_timer #(
    parameter int PERIOD = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    output logic zero
);

    localparam int          W      = (PERIOD > 1) ? $clog2(PERIOD) : 1;
    localparam logic [W-1:0] RELOAD = W'(PERIOD - 1);

    logic [W-1:0] cnt_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_reg <= '0;
        end else if (load) begin
            cnt_reg <= RELOAD;
        end else if (cnt_reg != '0) begin
            cnt_reg <= cnt_reg - 1'b1;
        end
    end

    assign zero = (cnt_reg == '0);

endmodule

// File: rtl/ddr4_cmd_encoder.sv
// DDR4 command/address bus driver: one-entry hold register, bank open tracking,
// minimum-spacing timers and illegal-sequence rejection.
module ddr4_cmd_encoder
    import ddr4_cmd_encoder_pkg::*;
#(
    parameter int T_RCD = 4,
    parameter int T_RP  = 4,
    parameter int T_RFC = 16,
    parameter int T_CCD = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [2:0]  req_op,
    input  logic [1:0]  req_ba,
    input  logic [1:0]  req_bg,
    input  logic [16:0] req_row,
    input  logic [9:0]  req_col,
    output logic        CS_n,
    output logic        ACT_n,
    output logic [16:0] adr,
    output logic [1:0]  ba,
    output logic [1:0]  bg,
    output logic        issued,
    output logic        err,
    output logic [16:0] cmd_count
);

    localparam int TMR_RCD = 0;
    localparam int TMR_RP  = 1;
    localparam int TMR_RFC = 2;
    localparam int TMR_CCD = 3;

    typedef enum logic {ST_EMPTY, ST_HELD} state_e;

    state_e      state_reg;
    req_t        hold_reg;
    req_t        req_in;
    bus_t        bus_reg;
    logic [15:0] open_mask_reg;
    logic        issued_reg;
    logic        err_reg;
    logic [16:0] cmd_count_reg;

    logic [3:0]  tmr_load;
    logic [3:0]  tmr_zero;
    logic [3:0]  slot;
    logic        slot_open;
    logic        timer_ok;
    logic        legal;
    logic        resolve;
    logic        do_issue;
    logic        do_drop;
    logic        accept;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : gen_tmr
            ddr4_timer #(
                .PERIOD((gi == TMR_RCD) ? T_RCD :
                        (gi == TMR_RP)  ? T_RP  :
                        (gi == TMR_RFC) ? T_RFC : T_CCD)
            ) u_tmr (
                .clk  (clk),
                .rst  (rst),
                .load (tmr_load[gi]),
                .zero (tmr_zero[gi])
            );
        end
    endgenerate

    assign req_in = '{op: op_e'(req_op), ba: req_ba, bg: req_bg,
                      row: req_row, col: req_col};

    assign slot      = {hold_reg.ba, hold_reg.bg};
    assign slot_open = open_mask_reg[slot];

    // Timer gating and legality of the held command; NOP is never gated
    always_comb begin
        timer_ok = 1'b1;
        legal    = 1'b1;
        case (hold_reg.op)
            OP_ACT: begin
                timer_ok = tmr_zero[TMR_RP] && tmr_zero[TMR_RFC];
                legal    = !slot_open;
            end
            OP_RD, OP_WR: begin
                timer_ok = tmr_zero[TMR_RCD] && tmr_zero[TMR_CCD] && tmr_zero[TMR_RFC];
                legal    = slot_open;
            end
            OP_PRE, OP_PREA: timer_ok = tmr_zero[TMR_RFC];
            OP_REF: begin
                timer_ok = tmr_zero[TMR_RP] && tmr_zero[TMR_RFC];
                legal    = (open_mask_reg == '0);
            end
            OP_MRS: begin
                timer_ok = tmr_zero[TMR_RFC];
                legal    = (open_mask_reg == '0);
            end
            default: begin
                timer_ok = 1'b1;
                legal    = 1'b1;
            end
        endcase
    end

    // A held command resolves (issue or drop) once its timers allow it
    assign resolve   = (state_reg == ST_HELD) && timer_ok;
    assign do_issue  = resolve && legal;
    assign do_drop   = resolve && !legal;
    assign req_ready = (state_reg == ST_EMPTY) || resolve;
    assign accept    = req_valid && req_ready;

    assign tmr_load[TMR_RCD] = do_issue && (hold_reg.op == OP_ACT);
    assign tmr_load[TMR_RP]  = do_issue && ((hold_reg.op == OP_PRE) || (hold_reg.op == OP_PREA));
    assign tmr_load[TMR_RFC] = do_issue && (hold_reg.op == OP_REF);
    assign tmr_load[TMR_CCD] = do_issue && ((hold_reg.op == OP_RD) || (hold_reg.op == OP_WR));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= ST_EMPTY;
            hold_reg      <= '0;
            bus_reg       <= bus_deselect();
            open_mask_reg <= '0;
            issued_reg    <= 1'b0;
            err_reg       <= 1'b0;
            cmd_count_reg <= '0;
        end else begin
            if (accept) begin
                hold_reg  <= req_in;
                state_reg <= ST_HELD;
            end else if (resolve) begin
                state_reg <= ST_EMPTY;
            end

            bus_reg    <= do_issue ? bus_encode(hold_reg) : bus_deselect();
            issued_reg <= do_issue;
            err_reg    <= do_drop;

            if (do_issue) begin
                cmd_count_reg <= cmd_count_reg + 17'd1;
                case (hold_reg.op)
                    OP_ACT:  open_mask_reg[slot] <= 1'b1;
                    OP_PRE:  open_mask_reg[slot] <= 1'b0;
                    OP_PREA: open_mask_reg       <= '0;
                    default: ;
                endcase
            end
        end
    end

    assign CS_n      = bus_reg.cs_n;
    assign ACT_n     = bus_reg.act_n;
    assign adr       = bus_reg.adr;
    assign ba        = bus_reg.ba;
    assign bg        = bus_reg.bg;
    assign issued    = issued_reg;
    assign err       = err_reg;
    assign cmd_count = cmd_count_reg;

endmodule

// File: tb/tb_ddr4_cmd_encoder.sv
// Self-checking bench: time-stamp model of the command bus compared every cycle,
// plus directed scenarios with hand-computed bus values and spacings.
module tb_ddr4_cmd_encoder;

    localparam int T_RCD = 4;
    localparam int T_RP  = 4;
    localparam int T_RFC = 16;
    localparam int T_CCD = 2;

    localparam logic [2:0] Q_ACT = 3'd0, Q_RD = 3'd1, Q_WR = 3'd2, Q_PRE = 3'd3,
                           Q_PREA = 3'd4, Q_REF = 3'd5, Q_MRS = 3'd6, Q_NOP = 3'd7;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [2:0]  req_op;
    logic [1:0]  req_ba, req_bg;
    logic [16:0] req_row;
    logic [9:0]  req_col;
    logic        CS_n, ACT_n;
    logic [16:0] adr;
    logic [1:0]  ba, bg;
    logic        issued, err;
    logic [16:0] cmd_count;

    ddr4_cmd_encoder #(.T_RCD(T_RCD), .T_RP(T_RP), .T_RFC(T_RFC), .T_CCD(T_CCD)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_op(req_op), .req_ba(req_ba), .req_bg(req_bg), .req_row(req_row),
        .req_col(req_col), .CS_n(CS_n), .ACT_n(ACT_n), .adr(adr), .ba(ba), .bg(bg),
        .issued(issued), .err(err), .cmd_count(cmd_count)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- behavioural model: issue-time stamps ----------------
    bit          model_on = 1'b0;
    int          e_cnt = 0;
    bit          m_held;
    logic [2:0]  m_op;
    logic [1:0]  m_ba, m_bg;
    logic [16:0] m_row;
    logic [9:0]  m_col;
    int          last_act, last_pre, last_ref, last_rw;
    bit          m_open [16];
    logic [16:0] m_count;
    logic [22:0] exp_bus;
    logic        exp_iss, exp_err;

    localparam logic [22:0] BUS_IDLE = {1'b1, 1'b1, 17'h1FFFF, 2'd0, 2'd0};

    function automatic bit spaced(int e);
        case (m_op)
            Q_ACT:        return (e - last_pre >= T_RP) && (e - last_ref >= T_RFC);
            Q_RD, Q_WR:   return (e - last_act >= T_RCD) && (e - last_rw >= T_CCD) &&
                                 (e - last_ref >= T_RFC);
            Q_REF:        return (e - last_pre >= T_RP) && (e - last_ref >= T_RFC);
            Q_NOP:        return 1'b1;
            default:      return (e - last_ref >= T_RFC);
        endcase
    endfunction

    function automatic bit any_open();
        for (int i = 0; i < 16; i++) if (m_open[i]) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [16:0] model_adr();
        case (m_op)
            Q_ACT:   return m_row;
            Q_RD:    return 17'h14000 | {7'd0, m_col};
            Q_WR:    return 17'h10000 | {7'd0, m_col};
            Q_PRE:   return 17'h08000;
            Q_PREA:  return 17'h08400;
            Q_REF:   return 17'h04000;
            Q_MRS:   return {3'b000, m_row[13:0]};
            default: return 17'h1C000;
        endcase
    endfunction

    always @(posedge clk) begin
        e_cnt++;
        if (rst) begin
            model_on = 1'b1;
            m_held   = 1'b0;
            last_act = -1000; last_pre = -1000; last_ref = -1000; last_rw = -1000;
            for (int i = 0; i < 16; i++) m_open[i] = 1'b0;
            m_count = '0;
            exp_bus = BUS_IDLE; exp_iss = 1'b0; exp_err = 1'b0;
        end else if (model_on) begin
            bit go, rdy, ok;
            int s;
            exp_bus = BUS_IDLE; exp_iss = 1'b0; exp_err = 1'b0;
            go  = m_held && spaced(e_cnt);
            rdy = !m_held || spaced(e_cnt);
            if (go) begin
                s = int'({m_ba, m_bg});
                case (m_op)
                    Q_ACT:        ok = !m_open[s];
                    Q_RD, Q_WR:   ok = m_open[s];
                    Q_REF, Q_MRS: ok = !any_open();
                    default:      ok = 1'b1;
                endcase
                if (ok) begin
                    exp_bus = {1'b0, (m_op == Q_ACT) ? 1'b0 : 1'b1, model_adr(), m_ba, m_bg};
                    exp_iss = 1'b1;
                    m_count = m_count + 17'd1;
                    case (m_op)
                        Q_ACT:  begin last_act = e_cnt; m_open[s] = 1'b1; end
                        Q_RD, Q_WR: last_rw = e_cnt;
                        Q_PRE:  begin last_pre = e_cnt; m_open[s] = 1'b0; end
                        Q_PREA: begin
                            last_pre = e_cnt;
                            for (int i = 0; i < 16; i++) m_open[i] = 1'b0;
                        end
                        Q_REF:  last_ref = e_cnt;
                        default: ;
                    endcase
                end else begin
                    exp_err = 1'b1;
                end
                m_held = 1'b0;
            end
            if (req_valid && rdy) begin
                m_held = 1'b1;
                m_op = req_op; m_ba = req_ba; m_bg = req_bg; m_row = req_row; m_col = req_col;
            end
        end
    end

    // ---------------- per-cycle compare and issue log ----------------
    typedef struct { int e; logic [16:0] a; } ent_t;
    ent_t iss_q[$];
    int   err_seen = 0;

    always @(negedge clk) begin
        if (model_on) begin
            check("bus", {9'd0, CS_n, ACT_n, adr, ba, bg}, {9'd0, exp_bus});
            check("issued", {31'd0, issued}, {31'd0, exp_iss});
            check("err", {31'd0, err}, {31'd0, exp_err});
            check("cmd_count", {15'd0, cmd_count}, {15'd0, m_count});
            check("req_ready", {31'd0, req_ready}, {31'd0, !m_held || spaced(e_cnt + 1)});
            if (issued) iss_q.push_back('{e: e_cnt, a: adr});
            if (err) err_seen++;
        end
    end

    function automatic int le(int i);
        return (i < iss_q.size()) ? iss_q[i].e : -1;
    endfunction

    function automatic logic [16:0] la(int i);
        return (i < iss_q.size()) ? iss_q[i].a : 17'h0;
    endfunction

    // ---------------- stimulus ----------------
    task automatic send(input logic [2:0] op, input logic [1:0] b_a, input logic [1:0] b_g,
                        input logic [16:0] row, input logic [9:0] col, output int acc);
        int waited = 0;
        req_valid = 1'b1; req_op = op; req_ba = b_a; req_bg = b_g; req_row = row; req_col = col;
        while (!req_ready && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        if (!req_ready) begin
            n_cmp++; n_bad++;
            $display("FAIL send_timeout: got ready=0 after %0d cycles expected ready=1", waited);
        end
        @(posedge clk);
        @(negedge clk);
        acc = e_cnt;
        req_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        int a0, a1, e0;
        logic [16:0] c0;
        rst = 1'b1; req_valid = 1'b0; req_op = '0; req_ba = '0; req_bg = '0;
        req_row = '0; req_col = '0;
        idle(3);
        rst = 1'b0;
        idle(2);

        // ACT then RD, back to back
        iss_q.delete();
        send(Q_ACT, 2'd0, 2'd0, 17'h01234, 10'd0, a0);
        send(Q_RD, 2'd0, 2'd0, 17'd0, 10'h010, a1);
        idle(20);
        check("s1_count", iss_q.size(), 2);
        check("s1_act_adr", {15'd0, la(0)}, 32'h01234);
        check("s1_act_latency", le(0) - a0, 1);
        check("s1_rd_adr", {15'd0, la(1)}, 32'h14010);
        check("s1_rcd_spacing", le(1) - le(0), T_RCD);

        // four RDs to the open bank
        iss_q.delete();
        c0 = cmd_count;
        for (int i = 0; i < 4; i++) send(Q_RD, 2'd0, 2'd0, 17'd0, 10'(i + 1), a0);
        idle(20);
        check("s2_count", iss_q.size(), 4);
        for (int i = 1; i < 4; i++) check("s2_ccd_spacing", le(i) - le(i - 1), T_CCD);
        check("s2_cmd_delta", {15'd0, 17'(cmd_count - c0)}, 4);

        // RD to a closed slot is dropped; the following WR is taken at once
        iss_q.delete();
        c0 = cmd_count;
        e0 = err_seen;
        send(Q_RD, 2'd1, 2'd0, 17'd0, 10'h005, a0);
        send(Q_WR, 2'd0, 2'd0, 17'd0, 10'h02A, a1);
        idle(10);
        check("s3_err_pulses", err_seen - e0, 1);
        check("s3_next_accept", a1 - a0, 1);
        check("s3_issue_count", iss_q.size(), 1);
        check("s3_wr_adr", {15'd0, la(0)}, 32'h1002A);
        check("s3_cmd_delta", {15'd0, 17'(cmd_count - c0)}, 1);

        // PREA, REF, ACT
        iss_q.delete();
        send(Q_PREA, 2'd0, 2'd0, 17'd0, 10'd0, a0);
        send(Q_REF, 2'd0, 2'd0, 17'd0, 10'd0, a0);
        send(Q_ACT, 2'd3, 2'd2, 17'h1ABCD, 10'd0, a0);
        idle(24);
        check("s4_prea_adr", {15'd0, la(0)}, 32'h08400);
        check("s4_ref_adr", {15'd0, la(1)}, 32'h04000);
        check("s4_rp_spacing", le(1) - le(0), T_RP);
        check("s4_act_adr", {15'd0, la(2)}, 32'h1ABCD);
        check("s4_rfc_spacing", le(2) - le(1), T_RFC);

        // close slot 14, then REF blocked by slot 5 until it is precharged
        send(Q_WR, 2'd3, 2'd2, 17'd0, 10'h3FF, a0);
        send(Q_PRE, 2'd3, 2'd2, 17'd0, 10'd0, a0);
        idle(10);
        iss_q.delete();
        e0 = err_seen;
        send(Q_ACT, 2'd1, 2'd1, 17'h00005, 10'd0, a0);
        send(Q_REF, 2'd0, 2'd0, 17'd0, 10'd0, a0);
        send(Q_PRE, 2'd1, 2'd1, 17'd0, 10'd0, a0);
        send(Q_REF, 2'd0, 2'd0, 17'd0, 10'd0, a0);
        send(Q_NOP, 2'd0, 2'd0, 17'd0, 10'd0, a0);
        send(Q_MRS, 2'd0, 2'd0, 17'h12ABC, 10'd0, a0);
        idle(24);
        check("s5_err_pulses", err_seen - e0, 1);
        check("s5_pre_adr", {15'd0, la(1)}, 32'h08000);
        check("s5_ref_adr", {15'd0, la(2)}, 32'h04000);
        check("s5_rp_spacing", le(2) - le(1), T_RP);
        check("s5_nop_ungated", le(3) - le(2), 1);
        check("s5_nop_adr", {15'd0, la(3)}, 32'h1C000);
        check("s5_mrs_adr", {15'd0, la(4)}, 32'h02ABC);
        check("s5_mrs_spacing", le(4) - le(2), T_RFC);

        // reset while an ACT is held behind a running refresh timer
        send(Q_REF, 2'd0, 2'd0, 17'd0, 10'd0, a0);
        send(Q_ACT, 2'd0, 2'd0, 17'h00777, 10'd0, a0);
        idle(5);
        #2 rst = 1'b1;
        @(negedge clk);
        check("rst_adr", {15'd0, adr}, 32'h1FFFF);
        check("rst_cmd_count", {15'd0, cmd_count}, 0);
        check("rst_open_mask", {16'd0, dut.open_mask_reg}, 0);
        #2 rst = 1'b0;
        @(negedge clk);
        iss_q.delete();
        send(Q_ACT, 2'd2, 2'd1, 17'h000FF, 10'd0, a0);
        idle(3);
        check("s6_issue_count", iss_q.size(), 1);
        check("s6_no_wait", le(0) - a0, 1);
        check("s6_act_adr", {15'd0, la(0)}, 32'h000FF);

        idle(3);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got no end of stimulus expected completion");
        $fatal(1, "watchdog");
    end

endmodule
